// File: rtl/alu_op_sequencer_if.sv
// Command and result channels between the issuing client and the ALU op sequencer.
// The master drives commands and consumes results; the slave is the sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [2:0]        cmd_op;

    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic [2:0]        res_op;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_op, res_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_op, res_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit combinational op unit: queues commands, drives one at a
// time onto the unit, and returns each captured result (or an error for bad opcodes).
//
// state | meaning
// IDLE  | waiting for a queued command; pops the head when one is present
// DRIVE | unit inputs held stable for one cycle; q captured at the closing edge
// RESP  | result presented on the result channel until it is consumed
module alu_op_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_op_sequencer_if.slave        bus,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [2:0]               alu_co,
    input  logic [RES_W-1:0]         alu_q,
    output logic [$clog2(DEPTH):0]   cmd_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              head_legal;

    logic              load_alu;
    logic              load_err;
    logic              capture;
    logic              res_done;

    logic              res_valid_q;
    logic [RES_W-1:0]  res_data_q;
    logic [2:0]        res_op_q;
    logic              res_err_q;

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = bus.cmd_valid && !fifo_full;
    assign head       = mem[rd_ptr];
    assign head_legal = (head.op != 3'd0) && (head.op <= 3'd5);

    assign bus.cmd_ready = !fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_err   = res_err_q;
    assign cmd_count     = count;

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_alu  = 1'b0;
        load_err  = 1'b0;
        capture   = 1'b0;
        res_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        load_alu  = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        load_err  = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            DRIVE: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (res_valid_q && bus.res_ready) begin
                    res_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_co      <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= 3'd0;
            res_err_q   <= 1'b0;
        end else begin
            if (load_alu) begin
                alu_a  <= head.a;
                alu_b  <= head.b;
                alu_co <= head.op;
            end
            // Illegal opcodes never reach the unit; the error is reported directly.
            if (load_err) begin
                res_data_q  <= '0;
                res_err_q   <= 1'b1;
                res_op_q    <= head.op;
                res_valid_q <= 1'b1;
            end
            if (capture) begin
                res_data_q  <= alu_q;
                res_err_q   <= 1'b0;
                res_op_q    <= alu_co;
                res_valid_q <= 1'b1;
                alu_co      <= 3'd0;
            end
            if (res_done) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a table model of the op unit drives alu_q,
// and a scoreboard queue checks every returned result in command order.
module tb_alu_op_sequencer;
    logic        clk;
    logic        rst_n;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_co;
    logic [15:0] alu_q;
    logic [2:0]  cmd_count;

    alu_op_sequencer_if #(.DATA_W(8), .RES_W(16)) bus ();

    alu_op_sequencer #(.DEPTH(4), .DATA_W(8), .RES_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_co    (alu_co),
        .alu_q     (alu_q),
        .cmd_count (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Op unit stand-in: returns the documented q for each directed vector.
    function automatic logic [15:0] unit_q(input logic [2:0] co, input logic [7:0] a,
                                           input logic [7:0] b);
        case ({co, a, b})
            {3'b011, 8'h02, 8'h03}: return 16'h0071;
            {3'b010, 8'h81, 8'h00}: return 16'h1020;
            {3'b100, 8'h09, 8'h04}: return 16'h0004;
            {3'b001, 8'h07, 8'h00}: return 16'h0001;
            {3'b101, 8'h01, 8'h01}: return 16'h0400;
            {3'b100, 8'h03, 8'h08}: return 16'h0003;
            default:                return 16'hDEAD;
        endcase
    endfunction

    assign alu_q = unit_q(alu_co, alu_a, alu_b);

    int   n_checks = 0;
    int   n_pass   = 0;
    logic bad_co   = 1'b0;
    logic [19:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (alu_co === 3'b110 || alu_co === 3'b111) bad_co = 1'b1;
        if (rst_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {16'd0, bus.res_data}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("res_data", {16'd0, bus.res_data}, {16'd0, e[15:0]});
                check("res_op",   {29'd0, bus.res_op},   {29'd0, e[18:16]});
                check("res_err",  {31'd0, bus.res_err},  {31'd0, e[19]});
            end
        end
    end

    // Offers one command; returns in the cycle after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_d, input logic exp_e, output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                exp_q.push_back({exp_e, op, exp_d});
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;

        // T1 reset values
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_cmd_count", {29'd0, cmd_count},     32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data",  {16'd0, bus.res_data},  32'd0);
        check("rst_res_op",    {29'd0, bus.res_op},    32'd0);
        check("rst_res_err",   {31'd0, bus.res_err},   32'd0);
        check("rst_alu_a",     {24'd0, alu_a},         32'd0);
        check("rst_alu_b",     {24'd0, alu_b},         32'd0);
        check("rst_alu_co",    {29'd0, alu_co},        32'd0);
        @(posedge clk);
        #1;

        // T2 single legal op, latency
        bus.res_ready = 1'b1;
        send(3'b011, 8'd2, 8'd3, 16'h0071, 1'b0, w);
        @(negedge clk);
        check("t2_co_n1",    {29'd0, alu_co},        32'd0);
        @(negedge clk);
        check("t2_co_n2",    {29'd0, alu_co},        32'd3);
        check("t2_a_n2",     {24'd0, alu_a},         32'd2);
        check("t2_b_n2",     {24'd0, alu_b},         32'd3);
        check("t2_valid_n2", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        check("t2_valid_n3", {31'd0, bus.res_valid}, 32'd1);
        wait_drain("t2_drain");

        // T3 back-to-back legal ops
        send(3'b010, 8'h81, 8'h00, 16'h1020, 1'b0, w);
        send(3'b100, 8'h09, 8'h04, 16'h0004, 1'b0, w);
        send(3'b001, 8'h07, 8'h00, 16'h0001, 1'b0, w);
        send(3'b101, 8'h01, 8'h01, 16'h0400, 1'b0, w);
        wait_drain("t3_drain");

        // T4 illegal op then legal op
        send(3'b110, 8'h00, 8'h00, 16'h0000, 1'b1, w);
        @(negedge clk);
        check("t4_valid_n1", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        check("t4_valid_n2", {31'd0, bus.res_valid}, 32'd1);
        check("t4_err_n2",   {31'd0, bus.res_err},   32'd1);
        check("t4_co_n2",    {29'd0, alu_co},        32'd0);
        @(posedge clk);
        #1;
        send(3'b100, 8'h03, 8'h08, 16'h0003, 1'b0, w);
        wait_drain("t4_drain");

        // T5 backpressure: DEPTH+1 accepted, then full
        bus.res_ready = 1'b0;
        send(3'b011, 8'h02, 8'h03, 16'h0071, 1'b0, w); check("t5_acc0", w, 32'd0);
        send(3'b010, 8'h81, 8'h00, 16'h1020, 1'b0, w); check("t5_acc1", w, 32'd0);
        send(3'b100, 8'h09, 8'h04, 16'h0004, 1'b0, w); check("t5_acc2", w, 32'd0);
        send(3'b001, 8'h07, 8'h00, 16'h0001, 1'b0, w); check("t5_acc3", w, 32'd0);
        send(3'b101, 8'h01, 8'h01, 16'h0400, 1'b0, w); check("t5_acc4", w, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b001;
        bus.cmd_a     = 8'hEE;
        bus.cmd_b     = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_full_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check("t5_full_count", {29'd0, cmd_count},     32'd4);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_ready_at_pop",   {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        check("t5_ready_after_pop", {31'd0, bus.cmd_ready}, 32'd1);
        wait_drain("t5_drain");

        // T6 reset during DRIVE with three commands queued
        send(3'b010, 8'h81, 8'h00, 16'h1020, 1'b0, w);
        send(3'b100, 8'h09, 8'h04, 16'h0004, 1'b0, w);
        send(3'b001, 8'h07, 8'h00, 16'h0001, 1'b0, w);
        send(3'b101, 8'h01, 8'h01, 16'h0400, 1'b0, w);
        send(3'b011, 8'h02, 8'h03, 16'h0071, 1'b0, w);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (alu_co !== 3'd0) seen = 1'b1;
            end
            check("t6_drive_seen",  {31'd0, seen},      32'd1);
            check("t6_queued",      {29'd0, cmd_count}, 32'd3);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("t6_count",     {29'd0, cmd_count},     32'd0);
        check("t6_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("t6_alu_co",    {29'd0, alu_co},        32'd0);
        check("t6_res_valid", {31'd0, bus.res_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_no_stale_count", {29'd0, cmd_count}, 32'd0);
        @(posedge clk);
        #1;
        send(3'b100, 8'h09, 8'h04, 16'h0004, 1'b0, w);
        wait_drain("t6_drain");

        check("alu_co_never_illegal", {31'd0, bad_co}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
